// File: rtl/uart_program_loader.sv
// Purpose : UART (8N1) boot loader; writes a framed, checksummed program image into RAM as 32-bit words
//           and holds the core in reset until a complete image with a valid checksum has landed.
// Latency : byte_valid one cycle after the stop-bit sample; mem_wren/cpu_reset_n/err one cycle after byte_valid.
// Backpressure: none; the serial line limits traffic to one byte per 10 bit times, so no buffering is needed.
// Ports   : clk, reset (sync, active-low), rx (async serial in) ->
//           mem_addr/mem_data/mem_wren (RAM write port), cpu_reset_n, busy, err (sticky).
module uart_program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    SYNC    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {HUNT, LEN_LO, LEN_HI, DATA, CSUM, RUN} ld_st_t;

  // RX front end state
  logic          rx_s1_q, rx_s1_d;
  logic          rx_s2_q, rx_s2_d;
  logic          rx_prev_q, rx_prev_d;
  rx_st_t        rx_st_q, rx_st_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err_q, frame_err_d;

  // Loader state
  ld_st_t        ld_st_q, ld_st_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic [23:0]   word_buf_q, word_buf_d;
  logic [7:0]    sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          mem_wren_q, mem_wren_d;
  logic          cpu_reset_n_q, cpu_reset_n_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  // The received byte stays in the shift register for at least half a bit
  // time after byte_vld_q, since a new start bit has to be confirmed before
  // any data bit is shifted in.
  logic [7:0] rx_byte;
  assign rx_byte = shift_q;

  always_comb begin
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_st_d     = rx_st_q;
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
      end
      RX_START: begin
        // Mid-start re-check: a line already back high was only a glitch.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          rx_st_d   = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          rx_st_d   = RX_IDLE;
          if (rx_s2_q) byte_vld_d  = 1'b1;
          else         frame_err_d = 1'b1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_st_d       = ld_st_q;
    len_d         = len_q;
    word_cnt_d    = word_cnt_q;
    lane_d        = lane_q;
    word_buf_d    = word_buf_q;
    sum_d         = sum_q;
    addr_d        = addr_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    cpu_reset_n_d = cpu_reset_n_q;
    err_d         = err_q;
    if (frame_err_q) begin
      // A broken byte invalidates the frame; the core keeps its current reset state.
      ld_st_d = HUNT;
      err_d   = 1'b1;
    end else if (byte_vld_q) begin
      case (ld_st_q)
        HUNT, RUN: begin
          if (rx_byte == SYNC) begin
            ld_st_d       = LEN_LO;
            err_d         = 1'b0;
            cpu_reset_n_d = 1'b0;
            sum_d         = '0;
            addr_d        = '0;
            lane_d        = '0;
            word_cnt_d    = '0;
          end
        end
        LEN_LO: begin
          len_d   = {len_q[15:8], rx_byte};
          ld_st_d = LEN_HI;
        end
        LEN_HI: begin
          len_d   = {rx_byte, len_q[7:0]};
          ld_st_d = ({rx_byte, len_q[7:0]} == 16'd0) ? CSUM : DATA;
        end
        DATA: begin
          // Little-endian: each byte enters at the top and shifts down.
          sum_d      = sum_q + rx_byte;
          word_buf_d = {rx_byte, word_buf_q[23:8]};
          lane_d     = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            mem_wren_d = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = {rx_byte, word_buf_q};
            addr_d     = addr_q + ADDR_W'(1);
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) ld_st_d = CSUM;
          end
        end
        CSUM: begin
          if (rx_byte == sum_q) begin
            ld_st_d       = RUN;
            cpu_reset_n_d = 1'b1;
          end else begin
            ld_st_d = HUNT;
            err_d   = 1'b1;
          end
        end
        default: ld_st_d = HUNT;
      endcase
    end
    busy_d = (ld_st_d == LEN_LO) || (ld_st_d == LEN_HI) ||
             (ld_st_d == DATA)   || (ld_st_d == CSUM);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_st_q       <= RX_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_vld_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      ld_st_q       <= HUNT;
      len_q         <= '0;
      word_cnt_q    <= '0;
      lane_q        <= '0;
      word_buf_q    <= '0;
      sum_q         <= '0;
      addr_q        <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_prev_q     <= rx_prev_d;
      rx_st_q       <= rx_st_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_vld_q    <= byte_vld_d;
      frame_err_q   <= frame_err_d;
      ld_st_q       <= ld_st_d;
      len_q         <= len_d;
      word_cnt_q    <= word_cnt_d;
      lane_q        <= lane_d;
      word_buf_q    <= word_buf_d;
      sum_q         <= sum_d;
      addr_q        <= addr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: one DUT at ADDR_W=10 and one at ADDR_W=2
// share the same serial line; RAM writes of each are logged from the negative clock edge.
module tb_uart_program_loader;
  localparam int C = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren, cpu_reset_n, busy, err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_data;
  logic        s_mem_wren, s_cpu_reset_n, s_busy, s_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa[$], wd[$], sa[$], sd[$];
  logic [7:0]  tx[$];

  uart_program_loader #(.CLKS_PER_BIT(C), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .err(err)
  );

  uart_program_loader #(.CLKS_PER_BIT(C), .ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_addr(s_mem_addr), .mem_data(s_mem_data), .mem_wren(s_mem_wren),
    .cpu_reset_n(s_cpu_reset_n), .busy(s_busy), .err(s_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren) begin
      wa.push_back(32'(mem_addr));
      wd.push_back(mem_data);
    end
    if (s_mem_wren) begin
      sa.push_back(32'(s_mem_addr));
      sd.push_back(s_mem_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = ~bad_stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_tx();
    while (tx.size() > 0) send_byte(tx.pop_front(), 1'b0);
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); sa.delete(); sd.delete();
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    check("rst_mem_wren", 32'(mem_wren), 32'h0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Noise: non-sync bytes and a one-cycle glitch are ignored
    tx = '{8'h00, 8'hFF};
    send_tx();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4 * C) @(negedge clk);
    check("noise_err", 32'(err), 32'h0);
    check("noise_busy", 32'(busy), 32'h0);
    check("noise_cpu", 32'(cpu_reset_n), 32'h0);
    check("noise_writes", 32'(wa.size()), 32'd0);

    // N = 0 frame
    tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_tx();
    check("n0_cpu", 32'(cpu_reset_n), 32'h1);
    check("n0_err", 32'(err), 32'h0);
    check("n0_busy", 32'(busy), 32'h0);
    check("n0_writes", 32'(wa.size()), 32'd0);

    // Good load, entered from RUN: sync drops cpu_reset_n
    send_byte(8'hA5, 1'b0);
    check("good_sync_cpu", 32'(cpu_reset_n), 32'h0);
    check("good_sync_busy", 32'(busy), 32'h1);
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_tx();
    check("good_pre_csum_cpu", 32'(cpu_reset_n), 32'h0);
    send_byte(8'h82, 1'b0);
    check("good_writes", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check("good_w0_addr", wa[0], 32'h0);
      check("good_w0_data", wd[0], 32'h0000_0013);
      check("good_w1_addr", wa[1], 32'h1);
      check("good_w1_data", wd[1], 32'h0000_006F);
    end
    check("good_cpu", 32'(cpu_reset_n), 32'h1);
    check("good_err", 32'(err), 32'h0);
    check("good_busy", 32'(busy), 32'h0);
    check("good_hold_addr", 32'(mem_addr), 32'h1);
    check("good_hold_data", mem_data, 32'h0000_006F);

    // Bad checksum
    clear_logs();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h83};
    send_tx();
    check("badcs_writes", 32'(wa.size()), 32'd2);
    check("badcs_err", 32'(err), 32'h1);
    check("badcs_cpu", 32'(cpu_reset_n), 32'h0);
    check("badcs_busy", 32'(busy), 32'h0);

    // Framing error on the second payload byte
    clear_logs();
    tx = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_tx();
    check("fe_sync_clears_err", 32'(err), 32'h0);
    check("fe_busy_before", 32'(busy), 32'h1);
    send_byte(8'h22, 1'b1);
    check("fe_err", 32'(err), 32'h1);
    check("fe_busy", 32'(busy), 32'h0);
    tx = '{8'h33, 8'h44};
    send_tx();
    check("fe_no_write", 32'(wa.size()), 32'd0);
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    send_tx();
    check("fe_recover_err", 32'(err), 32'h0);
    check("fe_recover_cpu", 32'(cpu_reset_n), 32'h1);
    check("fe_recover_writes", 32'(wa.size()), 32'd2);

    // Reload from RUN
    clear_logs();
    send_byte(8'hA5, 1'b0);
    check("reload_cpu_drop", 32'(cpu_reset_n), 32'h0);
    tx = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    send_tx();
    check("reload_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("reload_addr", wa[0], 32'h0);
      check("reload_data", wd[0], 32'hDDCC_BBAA);
    end
    check("reload_cpu", 32'(cpu_reset_n), 32'h1);

    // Reset mid-DATA (one word written, second word partial)
    clear_logs();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_tx();
    check("mid_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) check("mid_data", wd[0], 32'h0403_0201);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_addr", 32'(mem_addr), 32'h0);
    check("mid_rst_data", mem_data, 32'h0);
    check("mid_rst_wren", 32'(mem_wren), 32'h0);
    check("mid_rst_cpu", 32'(cpu_reset_n), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    tx = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0E};
    send_tx();
    check("post_rst_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("post_rst_addr", wa[0], 32'h0);
      check("post_rst_data", wd[0], 32'hDDCC_BBAA);
    end
    check("post_rst_cpu", 32'(cpu_reset_n), 32'h1);

    // Address wrap: N = 5 words of value 1..5, sum 0x0F
    clear_logs();
    tx = '{8'hA5, 8'h05, 8'h00};
    for (int k = 1; k <= 5; k++) begin
      tx.push_back(8'(k));
      tx.push_back(8'h00);
      tx.push_back(8'h00);
      tx.push_back(8'h00);
    end
    tx.push_back(8'h0F);
    send_tx();
    check("wrap_writes", 32'(wa.size()), 32'd5);
    check("wrap_small_writes", 32'(sa.size()), 32'd5);
    if (wa.size() == 5) begin
      check("wrap_big_last_addr", wa[4], 32'h4);
      check("wrap_big_last_data", wd[4], 32'h5);
    end
    if (sa.size() == 5) begin
      check("wrap_small_w3_addr", sa[3], 32'h3);
      check("wrap_small_last_addr", sa[4], 32'h0);
      check("wrap_small_last_data", sd[4], 32'h5);
    end
    check("wrap_cpu", 32'(cpu_reset_n), 32'h1);
    check("wrap_small_cpu", 32'(s_cpu_reset_n), 32'h1);
    check("wrap_small_err", 32'(s_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Serial boot loader placed upstream of the RISC-V core and its unified instruction/data RAM. It receives a framed program image over a UART RX line and writes it into RAM as 32-bit words. It holds the core in reset until a complete image with a valid checksum has been written. Its write port is muxed onto the RAM while `cpu_reset_n` is low.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `ADDR_W`, 10: RAM word-address width.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous UART line; idle high; 8N1, LSB first.
- `mem_addr` out ADDR_W: word address for the RAM write.
- `mem_data` out 32: word to write.
- `mem_wren` out 1: one-cycle RAM write strobe.
- `cpu_reset_n` out 1: 0 holds the core in reset; 1 releases it.
- `busy` out 1: high while a frame is being received (states LEN_LO through CSUM).
- `err` out 1: sticky error flag; cleared by `reset` or by the next valid sync byte.

## Operation
- **RX front end**
  - `rx` passes through a 2-flop synchronizer, reset to 1.
  - Start is detected on a synchronized falling edge.
  - The line is re-sampled at CLKS_PER_BIT/2 (integer division). If it is high, the event is a glitch: return to idle with no byte and no error.
  - Data bits are then sampled every CLKS_PER_BIT, LSB first, followed by the stop bit.
  - Stop bit = 1: a one-cycle internal `byte_valid` pulses with the byte.
  - Stop bit = 0: framing error. Set `err`, discard the byte, and force the loader FSM to HUNT.
- **Frame format (bytes)**
  - `0xA5` sync.
  - N[7:0], then N[15:8]: word count.
  - 4·N payload bytes, each word little-endian.
  - CSUM: 8-bit modulo-256 sum of the payload bytes only.
- **Loader FSM:** HUNT, LEN_LO, LEN_HI, DATA, CSUM, RUN.
  - HUNT:
    - `0xA5` → LEN_LO. Clear `err`, set `cpu_reset_n`=0, clear the sum, word address and byte lane.
    - Any other byte is ignored.
  - LEN_LO → LEN_HI on the next byte.
  - LEN_HI:
    - Next byte → DATA.
    - If N == 0, go directly to CSUM.
  - DATA:
    - Shift each byte into lane 0..3.
    - On lane 3, pulse `mem_wren` with the `mem_addr`/`mem_data` of the completed word, then increment the word address.
    - After word N is written → CSUM.
  - CSUM:
    - Match → RUN, `cpu_reset_n`=1.
    - Mismatch → HUNT, `err`=1, `cpu_reset_n` stays 0.
  - RUN:
    - `cpu_reset_n`=1, `busy`=0.
    - A received `0xA5` re-enters LEN_LO and drops `cpu_reset_n` to 0 (reload).
    - Other bytes are ignored.
- **Widths and arithmetic**
  - N is 16-bit unsigned.
  - Word address counter is ADDR_W bits and wraps modulo 2^ADDR_W. N > 2^ADDR_W overwrites from address 0; this is not an error.
  - Checksum accumulator is 8 bits and wraps.
- **Reset mid-frame:** the FSM returns to HUNT and the RX front end to idle. Partial words are discarded. Words already written remain in RAM.

## Timing
- **Reset values:** `mem_addr`=0, `mem_data`=0, `mem_wren`=0, `cpu_reset_n`=0, `busy`=0, `err`=0, FSM=HUNT.
- **Sampling:** stop bit sampled about 9.5·CLKS_PER_BIT cycles after the start edge. `byte_valid` is asserted the cycle after the stop sample.
- **Write strobe:** `mem_wren` is high for exactly the cycle after `byte_valid` of the lane-3 byte. `mem_addr`/`mem_data` are stable during that cycle and keep their values until the next write.
- **FSM-driven outputs:** `cpu_reset_n` and `err` update in the cycle after `byte_valid` of the CSUM byte (or of the sync byte).
- **Byte rate:** at most one byte per 10·CLKS_PER_BIT cycles, so back-to-back frames need no buffering. A start edge is accepted in the cycle after the stop sample.
- **Precedence:** framing error outranks the FSM transition of that byte slot. `reset` outranks everything.

## Test plan
- **Good load (CLKS_PER_BIT=4):**
  - Stimulus: A5 02 00 | 13 00 00 00 | 6F 00 00 00 | 82.
  - Required: two `mem_wren` pulses, addr 0 data 0x00000013 and addr 1 data 0x0000006F.
  - Required: `cpu_reset_n` rises after the CSUM byte; `err`=0.
- **Bad checksum:** same frame with CSUM 0x83 → both writes occur, `err`=1, `cpu_reset_n`=0, FSM in HUNT.
- **Noise and N=0:**
  - Leading 0x00 0xFF bytes and a 1-cycle low glitch on `rx` → ignored; no byte accepted, no error.
  - Then A5 00 00 00 → no writes, `cpu_reset_n`=1.
- **Framing error:** stop bit forced to 0 during the 2nd payload byte → `err`=1, HUNT, no write for that word. A following good frame clears `err` and loads.
- **Reload from RUN:** after a good load, send A5 01 00 AA BB CC DD 0E → `cpu_reset_n` drops at the sync byte. Required: write addr 0 data 0xDDCCBBAA, then `cpu_reset_n` returns to 1.
- **Reset and wrap:**
  - `reset` low mid-DATA → all outputs return to reset values; a new frame starts cleanly.
  - With ADDR_W=2 and N=5 → 5th word is written to address 0.
